// File: rtl/sap_u_control_sequencer_if.sv
// Control/bus bundle between the SAP_U control sequencer and the datapath it steers.
interface sap_u_control_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int STEP_W = 3
);
  logic [DATA_W-1:0] bus_in;
  logic              alu_carry;
  logic              alu_zero;
  logic [DATA_W-1:0] ir_bus_out;
  logic              ir_bus_enable_n;
  logic              ram_load_mar_reg_n;
  logic              ram_bus_enable_n;
  logic              ram_write_enable_n;
  logic              reg_a_load_n;
  logic              reg_a_bus_enable_n;
  logic              reg_b_load_n;
  logic              alu_enable_n;
  logic              alu_subtract;
  logic              program_counter_enable;
  logic              program_counter_bus_enable_n;
  logic              jump_n;
  logic              out_load;
  logic              halted;
  logic [STEP_W-1:0] step;

  modport master (
    input  bus_in, alu_carry, alu_zero,
    output ir_bus_out, ir_bus_enable_n, ram_load_mar_reg_n, ram_bus_enable_n,
           ram_write_enable_n, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n,
           alu_enable_n, alu_subtract, program_counter_enable,
           program_counter_bus_enable_n, jump_n, out_load, halted, step
  );

  modport slave (
    output bus_in, alu_carry, alu_zero,
    input  ir_bus_out, ir_bus_enable_n, ram_load_mar_reg_n, ram_bus_enable_n,
           ram_write_enable_n, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n,
           alu_enable_n, alu_subtract, program_counter_enable,
           program_counter_bus_enable_n, jump_n, out_load, halted, step
  );
endinterface

// File: rtl/sap_u_control_sequencer.sv
// SAP_U control stage: instruction register, microstep counter, flags and the
// combinational decode of {IR, step, flags} into the datapath control word.
module sap_u_control_sequencer #(
  parameter int DATA_W    = 8,
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 4,
  parameter int STEP_W    = 3
) (
  input  logic clk,
  input  logic reset,
  sap_u_control_sequencer_if.master ctrl
);
  typedef enum logic [STEP_W-1:0] {T0, T1, T2, T3, T4} step_t;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

  logic [DATA_W-1:0]   ir_reg;
  step_t               step_reg;
  logic                carry_reg;
  logic                zero_reg;
  logic                halted_reg;

  logic [OPCODE_W-1:0] op;
  logic [OPCODE_W-1:0] len_op;
  logic                is_last;

  function automatic step_t last_step_of(input logic [OPCODE_W-1:0] code);
    case (code)
      OP_LDA, OP_STA:                                 return T3;
      OP_ADD, OP_SUB:                                 return T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   return T2;
      default:                                        return T1;
    endcase
  endfunction

  assign op = ir_reg[DATA_W-1 -: OPCODE_W];
  // During T1 the IR still holds the previous instruction, so length comes from the bus.
  assign len_op  = (step_reg == T1) ? ctrl.bus_in[DATA_W-1 -: OPCODE_W] : op;
  assign is_last = (step_reg == last_step_of(len_op));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_reg     <= '0;
      step_reg   <= T0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      halted_reg <= 1'b0;
    end else if (!halted_reg) begin
      if (step_reg == T1)
        ir_reg <= ctrl.bus_in;
      if (step_reg == T4 && (op == OP_ADD || op == OP_SUB)) begin
        carry_reg <= ctrl.alu_carry;
        zero_reg  <= ctrl.alu_zero;
      end
      if (step_reg == T2 && op == OP_HLT)
        halted_reg <= 1'b1;
      step_reg <= is_last ? T0 : step_t'(step_reg + 1'b1);
    end
  end

  logic ir_oe, mar_ld, ram_oe, ram_we, a_ld, a_oe, b_ld, alu_oe, sub, pc_en, pc_oe, jump, out_ld;

  always_comb begin
    ir_oe = 1'b0; mar_ld = 1'b0; ram_oe = 1'b0; ram_we = 1'b0;
    a_ld = 1'b0; a_oe = 1'b0; b_ld = 1'b0; alu_oe = 1'b0; sub = 1'b0;
    pc_en = 1'b0; pc_oe = 1'b0; jump = 1'b0; out_ld = 1'b0;
    // Reset is folded in so every strobe drops the instant reset is asserted.
    if (reset && !halted_reg) begin
      case (step_reg)
        T0: begin pc_oe = 1'b1; mar_ld = 1'b1; end
        T1: begin ram_oe = 1'b1; pc_en = 1'b1; end
        T2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_oe = 1'b1; mar_ld = 1'b1; end
            OP_LDI: begin ir_oe = 1'b1; a_ld = 1'b1; end
            OP_JMP: begin ir_oe = 1'b1; jump = 1'b1; end
            OP_JC:  begin ir_oe = 1'b1; jump = carry_reg; end
            OP_JZ:  begin ir_oe = 1'b1; jump = zero_reg; end
            OP_OUT: begin a_oe = 1'b1; out_ld = 1'b1; end
            default: ;
          endcase
        end
        T3: begin
          case (op)
            OP_LDA: begin ram_oe = 1'b1; a_ld = 1'b1; end
            OP_ADD: begin ram_oe = 1'b1; b_ld = 1'b1; end
            OP_SUB: begin ram_oe = 1'b1; b_ld = 1'b1; sub = 1'b1; end
            OP_STA: begin a_oe = 1'b1; ram_we = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            alu_oe = 1'b1;
            a_ld   = 1'b1;
            sub    = (op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign ctrl.ir_bus_out                   = {{(DATA_W-OPERAND_W){1'b0}}, ir_reg[OPERAND_W-1:0]};
  assign ctrl.ir_bus_enable_n              = ~ir_oe;
  assign ctrl.ram_load_mar_reg_n           = ~mar_ld;
  assign ctrl.ram_bus_enable_n             = ~ram_oe;
  assign ctrl.ram_write_enable_n           = ~ram_we;
  assign ctrl.reg_a_load_n                 = ~a_ld;
  assign ctrl.reg_a_bus_enable_n           = ~a_oe;
  assign ctrl.reg_b_load_n                 = ~b_ld;
  assign ctrl.alu_enable_n                 = ~alu_oe;
  assign ctrl.alu_subtract                 = sub;
  assign ctrl.program_counter_enable       = pc_en;
  assign ctrl.program_counter_bus_enable_n = ~pc_oe;
  assign ctrl.jump_n                       = ~jump;
  assign ctrl.out_load                     = out_ld;
  assign ctrl.halted                       = halted_reg;
  assign ctrl.step                         = step_reg;
endmodule
